dbus_router: RTL and testbench

Parametrised 1-to-NUM_TGT data-bus router between the core data port and NUM_TGT targets (RAM, GPIO, future peripherals).
- Decodes each request against per-target base/mask regions.
- Tracks outstanding reads in an ordered ID FIFO, so every h_rvalid/h_rdata is steered from exactly the target that owns the oldest read.
- Answers unmapped accesses internally so the core never hangs.

---
 rtl/dbus_pkg.sv | 15 +
 rtl/dbus_id_fifo.sv | 37 +++
 rtl/dbus_router.sv | 100 ++++++++++
 tb/tb_dbus_router.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dbus_pkg.sv
// dbus_pkg: shared id type, error id and the default minisoc address map for dbus_router
`ifndef XLEN
`define XLEN 32
`endif
package dbus_pkg;
  localparam int TGT_MAX = 8;
  localparam int DEF_NUM_TGT = 4;
  // Sized for the largest supported router so one type serves every configuration
  typedef logic [$clog2(TGT_MAX+1)-1:0] tid_t;
  localparam tid_t ERR_ID = tid_t'(DEF_NUM_TGT);
  localparam logic [DEF_NUM_TGT*32-1:0] DEF_TGT_BASE =
    {32'h4000_0000, 32'h3000_0000, 32'h2000_0000, 32'h0000_0000};
  localparam logic [DEF_NUM_TGT*32-1:0] DEF_TGT_MASK =
    {32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'hE000_0000};
endpackage

// File: rtl/dbus_id_fifo.sv
// dbus_id_fifo: synchronous FIFO of target ids with occupancy count, full and empty
module dbus_id_fifo
  import dbus_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          push,
  input  logic          pop,
  input  tid_t          din,
  output tid_t          dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  logic [AW-1:0] wr_ptr, rd_ptr;
  tid_t mem [2**AW];
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr == LAST ? '0 : wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr == LAST ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
endmodule

// File: rtl/dbus_router.sv
// dbus_router: 1-to-NUM_TGT data bus router with in-order read steering and unmapped-access answering
// Optional DBUS_DECERR_EN adds h_rerr and the sticky err_addr capture.
`ifndef XLEN
`define XLEN 32
`endif
module dbus_router
  import dbus_pkg::*;
#(
  parameter int NUM_TGT = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter logic [NUM_TGT*32-1:0] TGT_BASE = DEF_TGT_BASE,
  parameter logic [NUM_TGT*32-1:0] TGT_MASK = DEF_TGT_MASK
) (
  input  logic                    clk,
  input  logic                    rst_b,
  input  logic                    h_req,
  input  logic                    h_write,
  input  logic [`XLEN/8-1:0]      h_wstrb,
  input  logic [`XLEN-1:0]        h_addr,
  input  logic [`XLEN-1:0]        h_wdata,
  output logic                    h_ready,
  output logic                    h_rvalid,
  output logic [`XLEN-1:0]        h_rdata,
  output logic [NUM_TGT-1:0]      t_req,
  output logic                    t_write,
  output logic [`XLEN/8-1:0]      t_wstrb,
  output logic [`XLEN-1:0]        t_addr,
  output logic [`XLEN-1:0]        t_wdata,
  input  logic [NUM_TGT-1:0]      t_ready,
  input  logic [NUM_TGT-1:0]      t_rvalid,
  input  logic [NUM_TGT*`XLEN-1:0] t_rdata
`ifdef DBUS_DECERR_EN
  ,
  output logic                    h_rerr,
  output logic [`XLEN-1:0]        err_addr
`endif
);
  localparam tid_t ERR_TID = tid_t'(NUM_TGT);
  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
  tid_t tid, head, last_tid;
  logic [NUM_TGT-1:0] hit_sel, head_sel;
  logic [`XLEN-1:0] rdata_mux;
  logic [CW-1:0] count;
  logic full, empty, read_stall, push, is_err, head_err, err_rvalid;
  // Descending scan so the lowest matching index wins on overlapping regions
  always_comb begin
    tid = ERR_TID;
    for (int i = NUM_TGT - 1; i >= 0; i--)
      if ((h_addr[31:0] & TGT_MASK[i*32 +: 32]) == TGT_BASE[i*32 +: 32]) tid = tid_t'(i);
  end
  always_comb begin
    hit_sel = '0;
    head_sel = '0;
    rdata_mux = '0;
    for (int i = 0; i < NUM_TGT; i++) begin
      hit_sel[i] = tid == tid_t'(i);
      head_sel[i] = head == tid_t'(i);
      if (head == tid_t'(i)) rdata_mux = t_rdata[i*`XLEN +: `XLEN];
    end
  end
  assign is_err = tid == ERR_TID;
  assign head_err = head == ERR_TID;
  // A read may only join the queue behind reads to the same target, keeping responses ordered
  assign read_stall = ~h_write & (full | (count != '0 & tid != last_tid));
  assign t_req = {NUM_TGT{h_req & ~read_stall}} & hit_sel;
  assign h_ready = ~read_stall & (is_err | |(t_ready & hit_sel));
  assign push = h_req & h_ready & ~h_write;
  assign h_rvalid = ~empty & (head_err ? err_rvalid : |(t_rvalid & head_sel));
  assign h_rdata = empty | head_err ? '0 : rdata_mux;
  assign t_write = h_write;
  assign t_wstrb = h_wstrb;
  assign t_addr = h_addr;
  assign t_wdata = h_wdata;
  dbus_id_fifo #(.DEPTH(MAX_OUTSTANDING), .CW(CW)) u_fifo (
    .clk(clk), .rst_b(rst_b), .push(push), .pop(h_rvalid), .din(tid),
    .dout(head), .count(count), .full(full), .empty(empty)
  );
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) begin
      last_tid <= '0;
      err_rvalid <= 1'b0;
    end else begin
      if (push) last_tid <= tid;
      err_rvalid <= push & is_err;
    end
`ifdef DBUS_DECERR_EN
  logic err_seen;
  assign h_rerr = h_rvalid & head_err;
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) begin
      err_seen <= 1'b0;
      err_addr <= '0;
    end else if (h_req & h_ready & is_err & ~err_seen) begin
      err_seen <= 1'b1;
      err_addr <= h_addr;
    end
`endif
  a_head_only: assert property (@(posedge clk) disable iff (!rst_b)
    !empty |-> (t_rvalid & ~head_sel) == '0);
endmodule

// File: tb/tb_dbus_router.sv
// tb_dbus_router: directed scenarios plus randomized traffic against a queue-based reference model
`ifndef XLEN
`define XLEN 32
`endif
module tb_dbus_router;
  localparam int N = 4;
  localparam int MO = 4;
  localparam logic [31:0] BASE [N] = '{32'h0000_0000, 32'h2000_0000, 32'h3000_0000, 32'h4000_0000};
  localparam logic [31:0] MASK [N] = '{32'hE000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000};
  logic clk = 1'b0;
  logic rst_b = 1'b0;
  logic h_req, h_write, h_ready, h_rvalid, t_write;
  logic [3:0] h_wstrb, t_wstrb;
  logic [31:0] h_addr, h_wdata, h_rdata, t_addr, t_wdata;
  logic [N-1:0] t_req, t_ready, t_rvalid;
  logic [N*32-1:0] t_rdata;
`ifdef DBUS_DECERR_EN
  logic h_rerr;
  logic [31:0] err_addr;
`endif
  int tests = 0;
  int fails = 0;

  dbus_router dut (
    .clk(clk), .rst_b(rst_b), .h_req(h_req), .h_write(h_write), .h_wstrb(h_wstrb),
    .h_addr(h_addr), .h_wdata(h_wdata), .h_ready(h_ready), .h_rvalid(h_rvalid),
    .h_rdata(h_rdata), .t_req(t_req), .t_write(t_write), .t_wstrb(t_wstrb),
    .t_addr(t_addr), .t_wdata(t_wdata), .t_ready(t_ready), .t_rvalid(t_rvalid),
    .t_rdata(t_rdata)
`ifdef DBUS_DECERR_EN
    , .h_rerr(h_rerr), .err_addr(err_addr)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got still running want finished");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    h_req = 1'b0; h_write = 1'b0; h_addr = '0; h_wdata = '0; h_wstrb = '0;
    t_ready = '1; t_rvalid = '0;
  endtask

  task automatic test_reset;
    idle;
    rst_b = 1'b0; h_req = 1'b1; h_addr = 32'h100; t_rvalid = 4'b0001;
    t_rdata = {4{32'hDEAD_BEEF}};
    step;
    tests++; if (h_rvalid !== 1'b0) begin fails++; $display("FAIL rst_rvalid got %b want 0", h_rvalid); end
    tests++; if (h_rdata !== 32'h0) begin fails++; $display("FAIL rst_rdata got %h want 0", h_rdata); end
    tests++; if (t_req !== 4'b0001) begin fails++; $display("FAIL rst_treq got %b want 0001", t_req); end
`ifdef DBUS_DECERR_EN
    tests++; if (h_rerr !== 1'b0) begin fails++; $display("FAIL rst_rerr got %b want 0", h_rerr); end
    tests++; if (err_addr !== 32'h0) begin fails++; $display("FAIL rst_erraddr got %h want 0", err_addr); end
`endif
    idle; step; rst_b = 1'b1; step;
  endtask

  task automatic test_single_read;
    idle; h_req = 1'b1; h_addr = 32'h100; #1;
    tests++; if (h_ready !== 1'b1) begin fails++; $display("FAIL rd1_ready got %b want 1", h_ready); end
    tests++; if (t_req !== 4'b0001) begin fails++; $display("FAIL rd1_treq got %b want 0001", t_req); end
    step; idle; t_rvalid[0] = 1'b1; t_rdata[31:0] = 32'h1234_5678; #1;
    tests++; if (h_rvalid !== 1'b1) begin fails++; $display("FAIL rd1_rvalid got %b want 1", h_rvalid); end
    tests++; if (h_rdata !== 32'h1234_5678) begin fails++; $display("FAIL rd1_rdata got %h want 12345678", h_rdata); end
    step; idle; h_req = 1'b1; h_addr = 32'h2000_0000; #1;
    tests++; if (h_ready !== 1'b1) begin fails++; $display("FAIL rd1_empty_ready got %b want 1", h_ready); end
    step; idle; t_rvalid[1] = 1'b1; t_rdata[63:32] = 32'h0000_CAFE; #1;
    tests++; if (h_rdata !== 32'h0000_CAFE) begin fails++; $display("FAIL rd1_t1_rdata got %h want 0000cafe", h_rdata); end
    step; idle;
  endtask

  task automatic test_full_stall;
    idle;
    for (int k = 0; k < MO; k++) begin
      h_req = 1'b1; h_addr = 32'h2000_0000; #1;
      tests++; if (h_ready !== 1'b1) begin fails++; $display("FAIL full_fill%0d got %b want 1", k, h_ready); end
      step;
    end
    #1;
    tests++; if (h_ready !== 1'b0) begin fails++; $display("FAIL full_ready got %b want 0", h_ready); end
    tests++; if (t_req !== 4'b0000) begin fails++; $display("FAIL full_treq got %b want 0000", t_req); end
    step;
    tests++; if (h_ready !== 1'b0) begin fails++; $display("FAIL full_hold got %b want 0", h_ready); end
    step; t_rvalid[1] = 1'b1; t_rdata[63:32] = 32'h0000_0011; #1;
    tests++; if (h_rvalid !== 1'b1) begin fails++; $display("FAIL full_pop_rvalid got %b want 1", h_rvalid); end
    tests++; if (h_ready !== 1'b0) begin fails++; $display("FAIL full_pop_ready got %b want 0", h_ready); end
    step; t_rvalid = '0; #1;
    tests++; if (h_ready !== 1'b1) begin fails++; $display("FAIL full_after_ready got %b want 1", h_ready); end
    tests++; if (t_req !== 4'b0010) begin fails++; $display("FAIL full_after_treq got %b want 0010", t_req); end
    step; h_req = 1'b0;
    for (int k = 0; k < MO; k++) begin
      t_rvalid[1] = 1'b1; #1;
      tests++; if (h_rvalid !== 1'b1) begin fails++; $display("FAIL full_drain%0d got %b want 1", k, h_rvalid); end
      step;
    end
    idle;
  endtask

  task automatic test_order_stall;
    idle; h_req = 1'b1; h_addr = 32'h0; #1;
    tests++; if (h_ready !== 1'b1) begin fails++; $display("FAIL ord_first got %b want 1", h_ready); end
    step; h_addr = 32'h2000_0004; #1;
    tests++; if (h_ready !== 1'b0) begin fails++; $display("FAIL ord_stall got %b want 0", h_ready); end
    tests++; if (t_req !== 4'b0000) begin fails++; $display("FAIL ord_stall_treq got %b want 0000", t_req); end
    step; t_rvalid[0] = 1'b1; t_rdata[31:0] = 32'h0000_A5A5; #1;
    tests++; if (h_rvalid !== 1'b1) begin fails++; $display("FAIL ord_pop got %b want 1", h_rvalid); end
    tests++; if (h_ready !== 1'b0) begin fails++; $display("FAIL ord_pop_ready got %b want 0", h_ready); end
    step; t_rvalid = '0; #1;
    tests++; if (t_req !== 4'b0010) begin fails++; $display("FAIL ord_fwd_treq got %b want 0010", t_req); end
    step; h_req = 1'b0; t_rvalid[1] = 1'b1; #1;
    tests++; if (h_rvalid !== 1'b1) begin fails++; $display("FAIL ord_t1_rvalid got %b want 1", h_rvalid); end
    step; idle;
  endtask

  task automatic test_write_bypass;
    idle; h_req = 1'b1; h_addr = 32'h0; #1;
    step; h_write = 1'b1; h_addr = 32'h2000_0008; h_wdata = 32'h5555_AAAA; h_wstrb = 4'b0110; #1;
    tests++; if (h_ready !== 1'b1) begin fails++; $display("FAIL wr_ready got %b want 1", h_ready); end
    tests++; if (t_req !== 4'b0010) begin fails++; $display("FAIL wr_treq got %b want 0010", t_req); end
    tests++; if ({t_write, t_wstrb, t_wdata} !== {1'b1, 4'b0110, 32'h5555_AAAA}) begin fails++; $display("FAIL wr_bcast got %b %b %h want 1 0110 5555aaaa", t_write, t_wstrb, t_wdata); end
    step; idle; t_rvalid[0] = 1'b1; #1;
    tests++; if (h_rvalid !== 1'b1) begin fails++; $display("FAIL wr_rd_rvalid got %b want 1", h_rvalid); end
    step; t_rvalid[0] = 1'b1; #1;
    tests++; if (h_rvalid !== 1'b0) begin fails++; $display("FAIL wr_count got %b want 0", h_rvalid); end
    step; idle;
  endtask

  task automatic test_unmapped;
    idle; t_ready = '0; h_req = 1'b1; h_addr = 32'h5000_0000; #1;
    tests++; if (h_ready !== 1'b1) begin fails++; $display("FAIL um_ready got %b want 1", h_ready); end
    tests++; if (t_req !== 4'b0000) begin fails++; $display("FAIL um_treq got %b want 0000", t_req); end
    step; idle; t_rdata = '1; #1;
    tests++; if (h_rvalid !== 1'b1) begin fails++; $display("FAIL um_rvalid got %b want 1", h_rvalid); end
    tests++; if (h_rdata !== 32'h0) begin fails++; $display("FAIL um_rdata got %h want 0", h_rdata); end
`ifdef DBUS_DECERR_EN
    tests++; if (h_rerr !== 1'b1) begin fails++; $display("FAIL um_rerr got %b want 1", h_rerr); end
    tests++; if (err_addr !== 32'h5000_0000) begin fails++; $display("FAIL um_erraddr got %h want 50000000", err_addr); end
`endif
    step; #1;
    tests++; if (h_rvalid !== 1'b0) begin fails++; $display("FAIL um_once got %b want 0", h_rvalid); end
    h_req = 1'b1; h_write = 1'b1; h_addr = 32'h6000_0000; #1;
    tests++; if (h_ready !== 1'b1) begin fails++; $display("FAIL um_wr_ready got %b want 1", h_ready); end
    step; idle; #1;
    tests++; if (h_rvalid !== 1'b0) begin fails++; $display("FAIL um_wr_noresp got %b want 0", h_rvalid); end
`ifdef DBUS_DECERR_EN
    tests++; if (err_addr !== 32'h5000_0000) begin fails++; $display("FAIL um_sticky got %h want 50000000", err_addr); end
`endif
    step;
  endtask

  task automatic test_reset_inflight;
    idle; h_req = 1'b1; h_addr = 32'h0;
    step; step; idle; #2;
    rst_b = 1'b0; t_rvalid[0] = 1'b1; #1;
    tests++; if (h_rvalid !== 1'b0) begin fails++; $display("FAIL rsti_rvalid got %b want 0", h_rvalid); end
`ifdef DBUS_DECERR_EN
    tests++; if (err_addr !== 32'h0) begin fails++; $display("FAIL rsti_erraddr got %h want 0", err_addr); end
`endif
    step; rst_b = 1'b1; t_rvalid[0] = 1'b1; #1;
    tests++; if (h_rvalid !== 1'b0) begin fails++; $display("FAIL rsti_late got %b want 0", h_rvalid); end
    step; t_rvalid = '0; h_req = 1'b1; h_addr = 32'h2000_0000; #1;
    tests++; if (h_ready !== 1'b1) begin fails++; $display("FAIL rsti_count got %b want 1", h_ready); end
    step; idle; t_rvalid[1] = 1'b1; #1;
    step; idle;
  endtask

  typedef struct { int tgt; logic [31:0] data; int acc; } rd_t;

  task automatic test_random;
    rd_t q[$];
    int cyc = 0;
    int exp_tid, sel;
    logic stall, exp_ready, exp_rvalid;
    logic [3:0] exp_treq;
    logic [31:0] exp_rdata;
    logic err_seen = 1'b0;
    logic [31:0] first_err = '0;
    idle;
    for (int n = 0; n < 3000; n++) begin
      step;
      cyc++;
      h_req = $urandom_range(0, 3) != 0;
      h_write = $urandom_range(0, 3) == 0;
      sel = $urandom_range(0, 6);
      h_addr = {sel < 6 ? 4'(sel) : 4'hA, 28'($urandom)};
      h_wdata = $urandom; h_wstrb = 4'($urandom);
      t_ready = 4'($urandom | $urandom);
      t_rdata = {$urandom, $urandom, $urandom, $urandom};
      t_rvalid = '0;
      if (q.size() > 0 && q[0].tgt < N && cyc > q[0].acc && $urandom_range(0, 2) == 0) begin
        t_rvalid[q[0].tgt] = 1'b1;
        t_rdata[q[0].tgt*32 +: 32] = q[0].data;
      end
      #1;
      exp_tid = N;
      for (int i = 0; i < N; i++) if (exp_tid == N && (h_addr & MASK[i]) == BASE[i]) exp_tid = i;
      stall = !h_write && (q.size() == MO || (q.size() > 0 && exp_tid != q[$].tgt));
      exp_ready = !stall && (exp_tid == N || t_ready[exp_tid] == 1'b1);
      exp_treq = (h_req && !stall && exp_tid < N) ? 4'(1 << exp_tid) : 4'b0;
      exp_rvalid = q.size() > 0 && (q[0].tgt == N ? cyc == q[0].acc + 1 : t_rvalid[q[0].tgt] == 1'b1);
      exp_rdata = (q.size() > 0 && q[0].tgt < N) ? q[0].data : 32'h0;
      tests++; if (h_ready !== exp_ready) begin fails++; $display("FAIL rnd_ready cyc %0d got %b want %b", cyc, h_ready, exp_ready); end
      tests++; if (t_req !== exp_treq) begin fails++; $display("FAIL rnd_treq cyc %0d got %b want %b", cyc, t_req, exp_treq); end
      tests++; if (h_rvalid !== exp_rvalid) begin fails++; $display("FAIL rnd_rvalid cyc %0d got %b want %b", cyc, h_rvalid, exp_rvalid); end
      if (exp_rvalid) begin
        tests++; if (h_rdata !== exp_rdata) begin fails++; $display("FAIL rnd_rdata cyc %0d got %h want %h", cyc, h_rdata, exp_rdata); end
      end
      tests++; if (t_addr !== h_addr || t_wdata !== h_wdata) begin fails++; $display("FAIL rnd_bcast cyc %0d got %h %h want %h %h", cyc, t_addr, t_wdata, h_addr, h_wdata); end
`ifdef DBUS_DECERR_EN
      tests++; if (h_rerr !== (exp_rvalid && q[0].tgt == N)) begin fails++; $display("FAIL rnd_rerr cyc %0d got %b", cyc, h_rerr); end
      tests++; if (err_addr !== first_err) begin fails++; $display("FAIL rnd_erraddr cyc %0d got %h want %h", cyc, err_addr, first_err); end
`endif
      if (exp_rvalid) void'(q.pop_front());
      if (h_req && exp_ready) begin
        if (!h_write) q.push_back('{exp_tid, $urandom, cyc});
        if (exp_tid == N && !err_seen) begin err_seen = 1'b1; first_err = h_addr; end
      end
    end
    step; idle;
  endtask

  initial begin
    idle;
    h_req = 1'b0;
    t_rdata = '0;
    test_reset;
    test_single_read;
    test_full_stall;
    test_order_stall;
    test_write_bypass;
    test_unmapped;
    test_reset_inflight;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
